// File: rtl/ray_sphere_scheduler.sv
// ray_sphere_scheduler: walks one ray across the sphere table. For each active
// sphere it asks the intersection unit for a hit. On a hit it asks the
// distance-compare unit, and it keeps the nearest hit. The result is returned
// through a single valid/ready handshake.
//
// Handshake rule for every channel: a transfer happens on a rising ACLK edge
// where valid && ready. A valid, once raised, stays high with a stable payload
// until that transfer. Payload outputs read 0 whenever their valid is low.
module ray_sphere_scheduler #(
  parameter int N_SPHERES_MAX = 16,
  parameter int COORD_W       = 16,
  parameter int DIST_W        = 16,
  parameter int IDX_W         = $clog2(N_SPHERES_MAX)
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_addr,
  input  logic [4*COORD_W-1:0] cfg_wdata,
  input  logic [IDX_W:0]       cfg_count,
  input  logic                 ray_valid,
  output logic                 ray_ready,
  input  logic [6*COORD_W-1:0] ray_data,
  output logic                 isect_in_valid,
  input  logic                 isect_in_ready,
  output logic [4*COORD_W-1:0] isect_sphere,
  output logic [6*COORD_W-1:0] isect_ray,
  input  logic                 isect_out_valid,
  output logic                 isect_out_ready,
  input  logic                 isect_hit,
  output logic                 dist_in_valid,
  input  logic                 dist_in_ready,
  output logic [DIST_W-1:0]    dist_old,
  input  logic                 dist_out_valid,
  output logic                 dist_out_ready,
  input  logic                 dist_hit,
  input  logic [DIST_W-1:0]    dist_value,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_hit,
  output logic [IDX_W-1:0]     res_index,
  output logic [DIST_W-1:0]    res_distance,
  output logic                 busy
);

  localparam logic [IDX_W:0] MAX_COUNT = (IDX_W+1)'(N_SPHERES_MAX);
  localparam logic [IDX_W:0] ONE_COUNT = (IDX_W+1)'(1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ISSUE_ISECT = 3'd1,
    WAIT_ISECT  = 3'd2,
    ISSUE_DIST  = 3'd3,
    WAIT_DIST   = 3'd4,
    NEXT        = 3'd5,
    DONE        = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [4*COORD_W-1:0] table_q [N_SPHERES_MAX];
  logic [6*COORD_W-1:0] ray_q;
  logic [IDX_W:0]       count_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DIST_W-1:0]    best_dist_q;
  logic [IDX_W-1:0]     best_idx_q;
  logic                 best_hit_q;

  logic [IDX_W:0] count_in;
  logic           ray_fire;
  logic           last_idx;
  logic           closer;

  // A count larger than the table depth is clamped to the table depth.
  assign count_in = (cfg_count > MAX_COUNT) ? MAX_COUNT : cfg_count;
  assign ray_fire = (state_q == IDLE) && ray_valid;
  assign last_idx = ({1'b0, idx_q} == (count_q - ONE_COUNT));
  // Strict compare: on a tie the earlier (lower-index) sphere is kept.
  assign closer   = dist_hit && (dist_value < best_dist_q);

  // Sphere table: loaded only while idle, so a ray in flight sees a frozen table.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < N_SPHERES_MAX; i++) begin
        table_q[i] <= '0;
      end
    end else if (cfg_we && (state_q == IDLE)) begin
      table_q[cfg_addr] <= cfg_wdata;
    end
  end

  // FSM state register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Per-ray context: latched ray, sphere cursor and the running best hit.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ray_q       <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      best_dist_q <= '1;
      best_idx_q  <= '0;
      best_hit_q  <= 1'b0;
    end else begin
      if (ray_fire) begin
        ray_q       <= ray_data;
        count_q     <= count_in;
        idx_q       <= '0;
        best_dist_q <= '1;
        best_idx_q  <= '0;
        best_hit_q  <= 1'b0;
      end
      if ((state_q == WAIT_DIST) && dist_out_valid && closer) begin
        best_dist_q <= dist_value;
        best_idx_q  <= idx_q;
        best_hit_q  <= 1'b1;
      end
      if ((state_q == NEXT) && !last_idx) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // Next-state decode and handshake/payload outputs, all driven from state.
  always_comb begin
    state_d         = state_q;
    ray_ready       = 1'b0;
    isect_in_valid  = 1'b0;
    isect_sphere    = '0;
    isect_ray       = '0;
    isect_out_ready = 1'b0;
    dist_in_valid   = 1'b0;
    dist_old        = '0;
    dist_out_ready  = 1'b0;
    res_valid       = 1'b0;
    res_hit         = 1'b0;
    res_index       = '0;
    res_distance    = '0;
    busy            = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        ray_ready = 1'b1;
        if (ray_valid) begin
          state_d = (count_in == '0) ? DONE : ISSUE_ISECT;
        end
      end
      ISSUE_ISECT: begin
        isect_in_valid = 1'b1;
        isect_sphere   = table_q[idx_q];
        isect_ray      = ray_q;
        if (isect_in_ready) state_d = WAIT_ISECT;
      end
      WAIT_ISECT: begin
        isect_out_ready = 1'b1;
        if (isect_out_valid) state_d = isect_hit ? ISSUE_DIST : NEXT;
      end
      ISSUE_DIST: begin
        dist_in_valid = 1'b1;
        dist_old      = best_dist_q;
        if (dist_in_ready) state_d = WAIT_DIST;
      end
      WAIT_DIST: begin
        dist_out_ready = 1'b1;
        if (dist_out_valid) state_d = NEXT;
      end
      NEXT: begin
        state_d = last_idx ? DONE : ISSUE_ISECT;
      end
      DONE: begin
        res_valid    = 1'b1;
        res_hit      = best_hit_q;
        res_index    = best_idx_q;
        res_distance = best_dist_q;
        if (res_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ray_sphere_scheduler.sv
// Bench for ray_sphere_scheduler. Partner units are modelled as behavioural
// responders. A reference model works out, for each ray, the expected request
// stream and the nearest-hit result. A monitor pops and compares these
// whenever the DUT transfers on a channel.
`timescale 1ns/1ps
module tb_ray_sphere_scheduler;
  localparam int N   = 16;
  localparam int CW  = 16;
  localparam int DW  = 16;
  localparam int IW  = 4;
  localparam int SW  = 4*CW;
  localparam int RW  = 6*CW;
  localparam int IQW = SW+RW;
  localparam int RQW = 1+IW+DW;

  logic           tb_ACLK = 1'b0;
  logic           ARESETn = 1'b0;
  logic           cfg_we = 1'b0;
  logic [IW-1:0]  cfg_addr = '0;
  logic [SW-1:0]  cfg_wdata = '0;
  logic [IW:0]    cfg_count = '0;
  logic           ray_valid = 1'b0;
  logic           ray_ready;
  logic [RW-1:0]  ray_data = '0;
  logic           isect_in_valid, isect_in_ready;
  logic [SW-1:0]  isect_sphere;
  logic [RW-1:0]  isect_ray;
  logic           isect_out_valid, isect_out_ready, isect_hit;
  logic           dist_in_valid, dist_in_ready;
  logic [DW-1:0]  dist_old;
  logic           dist_out_valid, dist_out_ready, dist_hit;
  logic [DW-1:0]  dist_value;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic           res_hit;
  logic [IW-1:0]  res_index;
  logic [DW-1:0]  res_distance;
  logic           busy;

  ray_sphere_scheduler dut (
    .ACLK(tb_ACLK), .ARESETn(ARESETn),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_count(cfg_count),
    .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_data(ray_data),
    .isect_in_valid(isect_in_valid), .isect_in_ready(isect_in_ready),
    .isect_sphere(isect_sphere), .isect_ray(isect_ray),
    .isect_out_valid(isect_out_valid), .isect_out_ready(isect_out_ready), .isect_hit(isect_hit),
    .dist_in_valid(dist_in_valid), .dist_in_ready(dist_in_ready), .dist_old(dist_old),
    .dist_out_valid(dist_out_valid), .dist_out_ready(dist_out_ready),
    .dist_hit(dist_hit), .dist_value(dist_value),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_hit(res_hit), .res_index(res_index), .res_distance(res_distance),
    .busy(busy)
  );

  // ---------------- clock / reset block ----------------
  always #5 tb_ACLK = ~tb_ACLK;
  int cyc = 0;
  always @(posedge tb_ACLK) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [IQW-1:0] isect_exp_q[$];
  logic           ihit_q[$];
  logic [DW-1:0]  dold_exp_q[$];
  logic [DW:0]    dresp_q[$];
  logic [RQW-1:0] res_exp_q[$];

  // Reference model contents: table image and per-sphere partner answers.
  logic [SW-1:0] tbl [N];
  logic          m_ihit [N];
  logic          m_dhit [N];
  logic [DW-1:0] m_dist [N];

  int rnd_mode    = 0;
  int isect_stall = 0;
  int dist_lat_fix = -1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Nearest hit over the active spheres, plus the request stream it implies.
  task automatic model_ray(input logic [IW:0] cnt, input logic [RW-1:0] ray);
    int n;
    logic [DW-1:0] best;
    logic          bh;
    logic [IW-1:0] bi;
    n = (int'(cnt) > N) ? N : int'(cnt);
    best = '1;
    bh = 1'b0;
    bi = '0;
    for (int i = 0; i < n; i++) begin
      isect_exp_q.push_back({tbl[i], ray});
      ihit_q.push_back(m_ihit[i]);
      if (m_ihit[i]) begin
        dold_exp_q.push_back(best);
        dresp_q.push_back({m_dhit[i], m_dist[i]});
        if (m_dhit[i] && (m_dist[i] < best)) begin
          best = m_dist[i];
          bh = 1'b1;
          bi = IW'(i);
        end
      end
    end
    res_exp_q.push_back({bh, bi, best});
  endtask

  function automatic logic [SW-1:0] sph(input int x, input int y, input int z, input int r);
    return {16'(x), 16'(y), 16'(z), 16'(r)};
  endfunction

  // ---------------- intersection unit responder ----------------
  initial begin : isect_partner
    logic pend, in_hs, out_hs, resp;
    int lat;
    pend = 1'b0; in_hs = 1'b0; out_hs = 1'b0; resp = 1'b0; lat = 0;
    isect_in_ready = 1'b0; isect_out_valid = 1'b0; isect_hit = 1'b0;
    forever begin
      @(negedge tb_ACLK);
      if (!ARESETn) begin
        pend = 1'b0; in_hs = 1'b0; out_hs = 1'b0;
        isect_in_ready = 1'b0; isect_out_valid = 1'b0; isect_hit = 1'b0;
      end else begin
        if (out_hs) begin
          check("isect_resp_expected", pend, 1'b1);
          pend = 1'b0; isect_out_valid = 1'b0; isect_hit = 1'b0;
        end
        if (in_hs) begin
          pend = 1'b1;
          isect_out_valid = 1'b0;
          lat = (rnd_mode != 0) ? int'($urandom_range(0, 3)) : 0;
          if (ihit_q.size() > 0) resp = ihit_q.pop_front();
          else resp = 1'b0;
        end
        if (pend) begin
          if (!isect_out_valid) begin
            if (lat == 0) begin
              isect_out_valid = 1'b1;
              isect_hit = resp;
            end else begin
              lat--;
            end
          end
        end else begin
          // Stray responses while nothing is outstanding must be ignored.
          isect_out_valid = (rnd_mode != 0) && ($urandom_range(0, 3) == 0);
          isect_hit = 1'b1;
        end
        if ((isect_stall > 0) && isect_in_valid) begin
          isect_in_ready = 1'b0;
          isect_stall--;
        end else begin
          isect_in_ready = (rnd_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        in_hs  = isect_in_valid && isect_in_ready;
        out_hs = isect_out_valid && isect_out_ready;
      end
    end
  end

  // ---------------- distance unit responder ----------------
  initial begin : dist_partner
    logic pend, in_hs, out_hs;
    logic [DW:0] resp;
    int lat;
    pend = 1'b0; in_hs = 1'b0; out_hs = 1'b0; resp = '0; lat = 0;
    dist_in_ready = 1'b0; dist_out_valid = 1'b0; dist_hit = 1'b0; dist_value = '0;
    forever begin
      @(negedge tb_ACLK);
      if (!ARESETn) begin
        pend = 1'b0; in_hs = 1'b0; out_hs = 1'b0;
        dist_in_ready = 1'b0; dist_out_valid = 1'b0; dist_hit = 1'b0; dist_value = '0;
      end else begin
        if (out_hs) begin
          check("dist_resp_expected", pend, 1'b1);
          pend = 1'b0; dist_out_valid = 1'b0;
        end
        if (in_hs) begin
          pend = 1'b1;
          dist_out_valid = 1'b0;
          if (dist_lat_fix >= 0) lat = dist_lat_fix;
          else lat = (rnd_mode != 0) ? int'($urandom_range(0, 3)) : 0;
          if (dresp_q.size() > 0) resp = dresp_q.pop_front();
          else resp = '0;
        end
        if (pend) begin
          if (!dist_out_valid) begin
            if (lat == 0) begin
              dist_out_valid = 1'b1;
              dist_hit = resp[DW];
              dist_value = resp[DW-1:0];
            end else begin
              lat--;
            end
          end
        end else begin
          dist_out_valid = (rnd_mode != 0) && ($urandom_range(0, 3) == 0);
          dist_hit = 1'b1;
          dist_value = '0;
        end
        dist_in_ready = (rnd_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        in_hs  = dist_in_valid && dist_in_ready;
        out_hs = dist_out_valid && dist_out_ready;
      end
    end
  end

  // ---------------- monitor: stability and transfer checks ----------------
  initial begin : monitor
    logic p_iv, p_dv, p_rv;
    logic [IQW-1:0] p_ipay;
    logic [DW-1:0]  p_dpay;
    logic [RQW-1:0] p_rpay;
    p_iv = 1'b0; p_dv = 1'b0; p_rv = 1'b0; p_ipay = '0; p_dpay = '0; p_rpay = '0;
    forever begin
      @(negedge tb_ACLK);
      #1;
      if (!ARESETn) begin
        p_iv = 1'b0; p_dv = 1'b0; p_rv = 1'b0;
      end else begin
        if (p_iv) check("isect_in_hold", {isect_in_valid, isect_sphere, isect_ray}, {1'b1, p_ipay});
        if (p_dv) check("dist_in_hold", {dist_in_valid, dist_old}, {1'b1, p_dpay});
        if (p_rv) check("res_hold", {res_valid, res_hit, res_index, res_distance}, {1'b1, p_rpay});
        if (isect_in_valid && isect_in_ready) begin
          if (isect_exp_q.size() == 0) fail_now("isect_extra_request");
          else check("isect_payload", {isect_sphere, isect_ray}, isect_exp_q.pop_front());
        end
        if (dist_in_valid && dist_in_ready) begin
          if (dold_exp_q.size() == 0) fail_now("dist_extra_request");
          else check("dist_old", dist_old, dold_exp_q.pop_front());
        end
        if (res_valid && res_ready) begin
          if (res_exp_q.size() == 0) fail_now("res_extra_result");
          else check("result", {res_hit, res_index, res_distance}, res_exp_q.pop_front());
        end
        p_iv = isect_in_valid && !isect_in_ready;
        p_ipay = {isect_sphere, isect_ray};
        p_dv = dist_in_valid && !dist_in_ready;
        p_dpay = dist_old;
        p_rv = res_valid && !res_ready;
        p_rpay = {res_hit, res_index, res_distance};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_idle_outputs(input string name);
    check({name, "_ctl"}, {ray_ready, busy, isect_in_valid, isect_out_ready,
                           dist_in_valid, dist_out_ready, res_valid}, 7'b1000000);
    check({name, "_payload"}, {isect_sphere, isect_ray, dist_old, res_hit, res_index, res_distance}, '0);
  endtask

  task automatic do_reset();
    @(negedge tb_ACLK);
    #3;
    ARESETn = 1'b0;
    ray_valid = 1'b0; res_ready = 1'b0; cfg_we = 1'b0;
    isect_stall = 0;
    isect_exp_q.delete(); ihit_q.delete(); dold_exp_q.delete();
    dresp_q.delete(); res_exp_q.delete();
    for (int i = 0; i < N; i++) tbl[i] = '0;
    #1;
    check_idle_outputs("reset_async");
    repeat (2) @(negedge tb_ACLK);
    #3;
    ARESETn = 1'b1;
  endtask

  task automatic cfg_write(input int a, input logic [SW-1:0] d);
    @(negedge tb_ACLK);
    cfg_we = 1'b1; cfg_addr = IW'(a); cfg_wdata = d;
    @(negedge tb_ACLK);
    cfg_we = 1'b0;
    tbl[a] = d;
  endtask

  task automatic set_models_miss();
    for (int i = 0; i < N; i++) begin
      m_ihit[i] = 1'b0; m_dhit[i] = 1'b0; m_dist[i] = '1;
    end
  endtask

  task automatic load_case2();
    cfg_write(0, sph(0, 0, 0, 2));
    cfg_write(1, sph(10, -10, 10, 2));
    set_models_miss();
    m_ihit[0] = 1'b1; m_dhit[0] = 1'b1; m_dist[0] = 16'd8;
  endtask

  // Submit one ray, wait for its result, optionally hold off res_ready.
  task automatic run_ray(input logic [IW:0] cnt, input logic [RW-1:0] ray,
                         input int exp_lat, input int res_hold, input bit busy_wr);
    int t_acc, waitc;
    model_ray(cnt, ray);
    @(negedge tb_ACLK);
    cfg_count = cnt; ray_data = ray; ray_valid = 1'b1;
    waitc = 0;
    while (!ray_ready && waitc < 50) begin
      @(negedge tb_ACLK);
      waitc++;
    end
    t_acc = cyc;
    @(negedge tb_ACLK);
    ray_valid = 1'b0;
    ray_data = {$urandom(), $urandom(), $urandom()};
    cfg_count = 5'($urandom_range(0, 31));
    if (busy_wr) begin
      cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = {$urandom(), $urandom()};
      @(negedge tb_ACLK);
      cfg_we = 1'b0;
    end
    waitc = 0;
    while (!res_valid && waitc < 2000) begin
      check("ray_ready_busy", {ray_ready, busy}, 2'b01);
      @(negedge tb_ACLK);
      waitc++;
    end
    if (!res_valid) begin
      fail_now("res_timeout");
      do_reset();
    end else begin
      if (exp_lat >= 0) check("res_latency", 256'(cyc - t_acc), 256'(exp_lat));
      repeat (res_hold) @(negedge tb_ACLK);
      res_ready = 1'b1;
      @(negedge tb_ACLK);
      res_ready = 1'b0;
      check("ray_ready_after_res", {ray_ready, busy, res_valid}, 3'b100);
      check("requests_drained", 256'(isect_exp_q.size() + ihit_q.size() + dold_exp_q.size()
                                     + dresp_q.size() + res_exp_q.size()), 256'(0));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int waitc;
    logic [IW:0] cnt;
    logic [RW-1:0] ray2;
    ray2 = {16'(0), 16'(10), 16'(0), 16'(0), -16'sd1, 16'(0)};
    for (int i = 0; i < N; i++) tbl[i] = '0;
    set_models_miss();

    @(negedge tb_ACLK);
    #1;
    check_idle_outputs("reset_hold");
    @(negedge tb_ACLK);
    #3;
    ARESETn = 1'b1;
    @(negedge tb_ACLK);
    #1;
    check_idle_outputs("after_reset");

    // Table reads 0 after reset; two misses cost 3 cycles each.
    run_ray(5'd2, {$urandom(), $urandom(), $urandom()}, 7, 0, 1'b0);

    // One hit at distance 8, one miss.
    load_case2();
    run_ray(5'd2, ray2, 9, 0, 1'b0);

    // Three hits 20, 8, 8: tie keeps index 1; result held under res_ready low.
    cfg_write(2, sph(5, 5, 5, 1));
    set_models_miss();
    m_ihit[0] = 1'b1; m_dhit[0] = 1'b1; m_dist[0] = 16'd20;
    m_ihit[1] = 1'b1; m_dhit[1] = 1'b1; m_dist[1] = 16'd8;
    m_ihit[2] = 1'b1; m_dhit[2] = 1'b1; m_dist[2] = 16'd8;
    run_ray(5'd3, {$urandom(), $urandom(), $urandom()}, 16, 3, 1'b0);

    // Empty table walk.
    run_ray(5'd0, {$urandom(), $urandom(), $urandom()}, 1, 2, 1'b0);

    // Intersection input stalled 4 cycles, and a table write while busy.
    load_case2();
    isect_stall = 4;
    run_ray(5'd2, ray2, 13, 0, 1'b1);
    run_ray(5'd2, ray2, 9, 0, 1'b0);

    // Reset while waiting on the distance unit.
    dist_lat_fix = 30;
    model_ray(5'd2, ray2);
    @(negedge tb_ACLK);
    cfg_count = 5'd2; ray_data = ray2; ray_valid = 1'b1;
    @(negedge tb_ACLK);
    ray_valid = 1'b0;
    waitc = 0;
    while (!dist_out_ready && waitc < 50) begin
      @(negedge tb_ACLK);
      waitc++;
    end
    check("reach_wait_dist", dist_out_ready, 1'b1);
    do_reset();
    dist_lat_fix = -1;
    @(negedge tb_ACLK);
    #1;
    check_idle_outputs("after_mid_reset");
    set_models_miss();
    run_ray(5'd1, ray2, 4, 0, 1'b0);
    load_case2();
    run_ray(5'd2, ray2, 9, 0, 1'b0);

    // Randomized traffic with random partner latency and backpressure.
    rnd_mode = 1;
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(0, 3)) cfg_write(int'($urandom_range(0, N-1)), {$urandom(), $urandom()});
      for (int i = 0; i < N; i++) begin
        m_ihit[i] = 1'($urandom_range(0, 1));
        m_dhit[i] = ($urandom_range(0, 4) != 0);
        m_dist[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 40));
      end
      if ($urandom_range(0, 3) == 0) cnt = 5'($urandom_range(17, 31));
      else cnt = 5'($urandom_range(0, 16));
      run_ray(cnt, {$urandom(), $urandom(), $urandom()}, -1, int'($urandom_range(0, 3)),
              (cnt != 0) && ($urandom_range(0, 3) == 0));
    end

    check("final_drain", 256'(isect_exp_q.size() + dold_exp_q.size() + res_exp_q.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ray_sphere_scheduler.md
# ray_sphere_scheduler

Sequencer that walks one ray across a table of spheres using the existing intersection unit and distance-compare unit, and reports the nearest hit. It sits in the PL between the AXI register front-end, which loads the sphere table and submits rays, and the two datapath units. It drives their valid/ready handshakes so software no longer polls each unit per sphere.

## Interface
- N_SPHERES_MAX, 16, sphere table depth; IDX_W = clog2(N_SPHERES_MAX)
- COORD_W, 16, signed two's-complement coordinate/radius/direction width
- DIST_W, 16, unsigned distance width
- ACLK  in  1  clock; all logic on rising edge
- ARESETn  in  1  asynchronous active-low reset
- cfg_we  in  1  sphere table write strobe
- cfg_addr  in  IDX_W  table entry
- cfg_wdata  in  4*COORD_W  {x,y,z,r}, x in MSBs
- cfg_count  in  IDX_W+1  active spheres; sampled at ray accept
- ray_valid / ray_ready  in / out  1  ray submit handshake
- ray_data  in  6*COORD_W  {sx,sy,sz,dx,dy,dz}, sx in MSBs
- isect_in_valid / isect_in_ready  out / in  1  request to intersection unit
- isect_sphere  out  4*COORD_W; isect_ray  out  6*COORD_W
- isect_out_valid / isect_out_ready  in / out  1; isect_hit  in  1
- dist_in_valid / dist_in_ready  out / in  1; dist_old  out  DIST_W
- dist_out_valid / dist_out_ready  in / out  1; dist_hit  in  1; dist_value  in  DIST_W
- res_valid / res_ready  out / in  1  result handshake
- res_hit  out  1; res_index  out  IDX_W; res_distance  out  DIST_W
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE_ISECT, WAIT_ISECT, ISSUE_DIST, WAIT_DIST, NEXT, DONE.
- Table: N_SPHERES_MAX x 4*COORD_W registers, reset to 0. cfg_we is accepted only in IDLE; writes while busy are dropped.
- IDLE: ray_ready=1. On ray_valid&&ray_ready: latch ray, latch count = min(cfg_count, N_SPHERES_MAX), idx=0, best_dist=all-ones, best_hit=0, best_idx=0. If count==0 go to DONE, else go to ISSUE_ISECT.
- ISSUE_ISECT: isect_in_valid=1, isect_sphere=table[idx], isect_ray=latched ray. On isect_in_ready go to WAIT_ISECT.
- WAIT_ISECT: isect_out_ready=1. On isect_out_valid, go to ISSUE_DIST if isect_hit, else to NEXT.
- ISSUE_DIST: dist_in_valid=1, dist_old=best_dist. On dist_in_ready go to WAIT_DIST.
- WAIT_DIST: dist_out_ready=1. On dist_out_valid with dist_hit and dist_value < best_dist (strict; ties keep lower index): best_dist=dist_value, best_idx=idx, best_hit=1. Then go to NEXT.
- NEXT: if idx==count-1 go to DONE, else idx++ and go to ISSUE_ISECT.
- DONE: res_valid=1 with res_hit=best_hit, res_index=best_idx, res_distance=best_dist. On res_ready go to IDLE.
- No hit: res_hit=0, res_index=0, res_distance=all-ones.
- Valids and their payloads are held stable until accepted. Responses arriving while the matching *_out_ready is low are ignored. Table reads are combinational from idx.

## Timing
- Reset values: all valid/ready outputs 0 except ray_ready=1 (IDLE); busy=0; payload outputs 0; best_dist all-ones.
- Reset mid-operation: immediate return to IDLE. In-flight requests are abandoned. The table is cleared.
- With zero-wait partners (ready tied 1, out_valid on the cycle after request), ray accepted at cycle T:
  - ISSUE_ISECT at T+1.
  - A miss costs 3 cycles; a hit costs 5 cycles.
  - res_valid rises at T+1+sum(per-sphere costs).
  - count==0 gives res_valid at T+1.
- ray_ready stays low from the accept cycle until the cycle after the res handshake.
- Partner wait states add cycles 1:1 and never drop or duplicate a request.

## Test plan
- Reset: ARESETn low for 2 cycles, then high → ray_ready=1, busy=0, res_valid=0, all other valids 0; table reads 0.
- count=2, table[0]=(0,0,0,2), table[1]=(10,-10,10,2), ray (0,10,0)/(0,-1,0). Models: hit/8 for sphere 0, miss for sphere 1 → exactly one dist request, with dist_old=0xFFFF; res_hit=1, res_index=0, res_distance=8; res_valid at T+9.
- count=3, model distances 20, 8, 8 (all hits) → dist_old sequence 0xFFFF, 20, 8; result index 1, distance 8 (tie keeps lower index).
- count=0 → res_valid at T+1, res_hit=0, res_index=0, res_distance=0xFFFF; no isect/dist requests issued.
- Backpressure:
  - isect_in_ready low 4 cycles → isect_in_valid and payload stable throughout.
  - res_ready low 3 cycles → result held stable.
  - cfg_we during busy → table unchanged.
- Reset asserted in WAIT_DIST → outputs return to reset values within the same cycle. A following ray with the case-2 setup after reloading the table yields the case-2 result.
